modal_buffer: RTL and testbench

MODAL_BUFFER -- requirements
Module: modal_buffer

---
 rtl/stack_pkg.sv | 20 ++
 rtl/wrap_ptr.sv | 29 ++
 rtl/modal_buffer.sv | 129 ++++++++++++
 tb/tb_modal_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and sizing helpers for the modal (FIFO/LIFO) buffer.
//   buf_mode_e  : ordering mode selector
//   cnt_width() : width of an occupancy counter able to hold 0..depth
//   ptr_width() : width of a storage index able to hold 0..depth-1
package stack_pkg;

    typedef enum logic [0:0] {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } buf_mode_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth + 1) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer: wraps DEPTH-1 -> 0 regardless of binary width.
//   clk, rst_n : clock, async active-low reset
//   en         : advance by one (mod DEPTH)
//   clr        : synchronous return to 0, wins over en
//   ptr        : current pointer value
module wrap_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/modal_buffer.sv
// Buffer that orders entries either first-in-first-out or last-in-first-out.
//   in_data/in_valid/in_ready    : write handshake (in_ready also high when a pop frees a slot)
//   out_data/out_valid/out_ready : show-ahead read handshake, out_data is '0 when empty
//   mode_req/mode                : requested / active ordering; changes only while idle and empty
//   flush                        : empties the buffer at the next edge, overriding push/pop
//   stat_clr                     : reloads peak with count and clears mode_err
//   count, peak                  : occupancy and high-water mark
//   full/empty/almost_*/mode_err : status flags
module modal_buffer
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 20,
    parameter int          AF_LEVEL   = int'(DEPTH) - 2,
    parameter int          AE_LEVEL   = 2,
    parameter buf_mode_e   RESET_MODE = MODE_FIFO
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  buf_mode_e                       mode_req,
    output buf_mode_e                       mode,
    input  logic                            flush,
    input  logic                            stat_clr,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic [cnt_width(DEPTH)-1:0]     peak,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            mode_err
);

    localparam int unsigned    CNT_W   = cnt_width(DEPTH);
    // Index width covers 0..DEPTH-1 for every DEPTH, including 2^k-1 sizes.
    localparam int unsigned    PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_addr, top_addr;
    logic [CNT_W-1:0]      count_nxt, peak_base, peak_nxt;
    logic                  push, pop, fifo, mode_chg, mode_apply, wr_en;

    // Status flags and handshakes, all derived from registered state.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign out_valid    = ~empty;
    assign in_ready     = ~full | out_ready;
    assign almost_full  = int'(count) >= AF_LEVEL;
    assign almost_empty = int'(count) <= AE_LEVEL;
    assign fifo         = (mode == MODE_FIFO);
    assign top_addr     = PTR_W'(count - CNT_W'(1));
    assign out_data     = empty ? '0 : mem[fifo ? rd_ptr : top_addr];

    // Next-state decisions.
    always_comb begin
        push       = in_valid & in_ready;
        pop        = out_valid & out_ready;
        mode_chg   = (mode_req != mode);
        mode_apply = mode_chg & empty & ~push;
        wr_en      = push & ~flush;
        // LIFO push+pop replaces the top entry in place.
        wr_addr    = fifo ? wr_ptr : (pop ? top_addr : PTR_W'(count));
        count_nxt  = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        peak_base = stat_clr ? count : peak;
        peak_nxt  = (count_nxt > peak_base) ? count_nxt : peak_base;
    end

    wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fifo & push & ~flush),
        .clr   (flush | mode_apply),
        .ptr   (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fifo & pop & ~flush),
        .clr   (flush | mode_apply),
        .ptr   (rd_ptr)
    );

    // Storage: single write port, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
    end

    // Occupancy, mode and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            peak     <= '0;
            mode     <= RESET_MODE;
            mode_err <= 1'b0;
        end else begin
            count <= count_nxt;
            peak  <= peak_nxt;
            if (mode_apply) begin
                mode <= mode_req;
            end
            if (mode_chg && !mode_apply) begin
                mode_err <= 1'b1;
            end else if (stat_clr) begin
                mode_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modal_buffer.sv
// Scoreboarded bench for modal_buffer: directed scenarios plus random traffic on a
// DEPTH=4 instance, and fill/drain sequences on DEPTH=5 and DEPTH=1 instances.
module tb_modal_buffer;
    import stack_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_data, out_data;
    logic       in_valid, in_ready, out_valid, out_ready, flush, stat_clr;
    buf_mode_e  mode_req, mode;
    logic [2:0] count, peak;
    logic       full, empty, almost_full, almost_empty, mode_err;

    modal_buffer #(.DATA_WIDTH(8), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mode_req(mode_req), .mode(mode), .flush(flush), .stat_clr(stat_clr),
        .count(count), .peak(peak), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .mode_err(mode_err)
    );

    // Small instances share data/handshake drivers, gated by sel.
    int         sel = 0;
    logic [7:0] s_in_data;
    logic       s_in_valid, s_out_ready;

    logic [7:0] d5_out_data, d1_out_data;
    logic       d5_in_ready, d5_out_valid, d5_full, d5_empty, d5_af, d5_ae, d5_err;
    logic       d1_in_ready, d1_out_valid, d1_full, d1_empty, d1_af, d1_ae, d1_err;
    buf_mode_e  d5_mode, d1_mode;
    logic [2:0] d5_count, d5_peak;
    logic       d1_count, d1_peak;

    modal_buffer #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid && sel == 0),
        .in_ready(d5_in_ready), .out_data(d5_out_data), .out_valid(d5_out_valid),
        .out_ready(s_out_ready && sel == 0), .mode_req(MODE_FIFO), .mode(d5_mode),
        .flush(1'b0), .stat_clr(1'b0), .count(d5_count), .peak(d5_peak), .full(d5_full),
        .empty(d5_empty), .almost_full(d5_af), .almost_empty(d5_ae), .mode_err(d5_err)
    );

    modal_buffer #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid && sel == 1),
        .in_ready(d1_in_ready), .out_data(d1_out_data), .out_valid(d1_out_valid),
        .out_ready(s_out_ready && sel == 1), .mode_req(MODE_FIFO), .mode(d1_mode),
        .flush(1'b0), .stat_clr(1'b0), .count(d1_count), .peak(d1_peak), .full(d1_full),
        .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae), .mode_err(d1_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: an ordered list of live entries plus mode and statistics.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    buf_mode_e  m_mode;
    int         m_peak;
    bit         m_err;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_mode = MODE_FIFO;
        m_peak = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == D));
        chk("out_valid", int'(out_valid), int'(n != 0));
        chk("almost_full", int'(almost_full), int'(n >= D - 2));
        chk("almost_empty", int'(almost_empty), int'(n <= 2));
        chk("mode", int'(mode), int'(m_mode));
        chk("peak", int'(peak), m_peak);
        chk("mode_err", int'(mode_err), int'(m_err));
        if (n == 0) chk("out_data_empty", int'(out_data), 0);
        else chk("out_data_head", int'(out_data), int'((m_mode == MODE_FIFO) ? mq[0] : mq[n-1]));
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input bit iv, input logic [7:0] dat, input bit orr,
                        input buf_mode_e mreq, input bit fl, input bit sc);
        int  old;
        bit  p_push, p_pop, fifo_now, set_err;
        int  base;
        check_state();
        in_valid  = iv;
        in_data   = dat;
        out_ready = orr;
        mode_req  = mreq;
        flush     = fl;
        stat_clr  = sc;
        #1;
        old = mq.size();
        chk("in_ready", int'(in_ready), int'(old < D || orr));
        p_push   = iv && (old < D || orr);
        p_pop    = orr && (old > 0);
        fifo_now = (m_mode == MODE_FIFO);
        set_err  = 1'b0;
        if (mreq != m_mode) begin
            if (old == 0 && !p_push) m_mode = mreq;
            else set_err = 1'b1;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (p_pop) exp_q.push_back(fifo_now ? mq.pop_front() : mq.pop_back());
            if (p_push) mq.push_back(dat);
        end
        base = sc ? old : m_peak;
        if (mq.size() > base) base = mq.size();
        m_peak = base;
        if (set_err) m_err = 1'b1;
        else if (sc) m_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_v(input logic [7:0] v);
        step(1'b1, v, 1'b0, m_mode, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, m_mode, 1'b0, 1'b0);
    endtask

    task automatic set_mode(input buf_mode_e m);
        step(1'b0, 8'h00, 1'b0, m, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        mode_req  = m_mode;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_exp_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        model_reset();
        mode_req = MODE_FIFO;
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted pop must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h with no pop predicted at %0t", out_data, $time);
            end else begin
                chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic get_small(input int d, output int f, output int e, output int ir,
                             output int od, output int cnt);
        if (d == 5) begin
            f = int'(d5_full); e = int'(d5_empty); ir = int'(d5_in_ready);
            od = int'(d5_out_data); cnt = int'(d5_count);
        end else begin
            f = int'(d1_full); e = int'(d1_empty); ir = int'(d1_in_ready);
            od = int'(d1_out_data); cnt = int'(d1_count);
        end
    endtask

    // Fill to capacity, confirm backpressure, then drain in arrival order.
    task automatic run_small(input int d);
        int f, e, ir, od, cnt;
        sel = (d == 5) ? 0 : 1;
        s_out_ready = 1'b0;
        for (int i = 0; i < d; i++) begin
            s_in_data  = 8'(17 * (i + 1));
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        #1;
        get_small(d, f, e, ir, od, cnt);
        chk($sformatf("d%0d_full", d), f, 1);
        chk($sformatf("d%0d_empty_when_full", d), e, 0);
        chk($sformatf("d%0d_in_ready_full", d), ir, 0);
        chk($sformatf("d%0d_count_full", d), cnt, d);
        for (int i = 0; i < d; i++) begin
            s_out_ready = 1'b1;
            #1;
            get_small(d, f, e, ir, od, cnt);
            chk($sformatf("d%0d_pop_%0d", d, i), od, 17 * (i + 1));
            @(posedge clk);
            #1;
        end
        s_out_ready = 1'b0;
        #1;
        get_small(d, f, e, ir, od, cnt);
        chk($sformatf("d%0d_empty_after", d), e, 1);
        chk($sformatf("d%0d_full_after", d), f, 0);
        chk($sformatf("d%0d_data_after", d), od, 0);
    endtask

    initial begin
        int pv, pr, r;
        bit iv, orr, fl, sc;
        buf_mode_e mreq;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        flush = 1'b0; stat_clr = 1'b0; mode_req = MODE_FIFO;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = 8'h00;
        model_reset();

        #3;
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_mode", int'(mode), int'(MODE_FIFO));
        chk("reset_almost_full", int'(almost_full), 0);
        chk("d1_reset_af_always", int'(d1_af), 1);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // FIFO fill then drain in order.
        push_v(8'h11); push_v(8'h22); push_v(8'h33); push_v(8'h44);
        pop_n(4);

        // LIFO ordering.
        set_mode(MODE_LIFO);
        push_v(8'hA1); push_v(8'hA2); push_v(8'hA3);
        pop_n(3);

        // Full LIFO with simultaneous push/pop replaces the top.
        for (int i = 1; i <= 4; i++) push_v(8'(i));
        step(1'b1, 8'h55, 1'b1, MODE_LIFO, 1'b0, 1'b0);
        pop_n(4);

        // Same on full FIFO; write pointer wraps 3 -> 0.
        set_mode(MODE_FIFO);
        for (int i = 1; i <= 4; i++) push_v(8'(i));
        step(1'b1, 8'h55, 1'b1, MODE_FIFO, 1'b0, 1'b0);
        pop_n(4);

        // Mode change refused while holding data, then statistics clear.
        push_v(8'h61); push_v(8'h62);
        set_mode(MODE_LIFO);
        step(1'b0, 8'h00, 1'b0, MODE_FIFO, 1'b0, 1'b1);
        pop_n(2);

        // Flush beats a coincident push.
        push_v(8'h71); push_v(8'h72); push_v(8'h73);
        step(1'b1, 8'h77, 1'b0, MODE_FIFO, 1'b1, 1'b0);
        check_state();

        // Asynchronous reset mid-stream, then only fresh data is seen.
        push_v(8'h81); push_v(8'h82);
        async_reset();
        push_v(8'h99);
        pop_n(1);

        // Random traffic in segments with varying push/pop pressure.
        for (int seg = 0; seg < 12; seg++) begin
            pv = 20 + 30 * int'($urandom_range(0, 2));
            pr = 20 + 30 * int'($urandom_range(0, 2));
            for (int c = 0; c < 150; c++) begin
                iv   = ($urandom_range(0, 99) < pv);
                orr  = ($urandom_range(0, 99) < pr);
                fl   = ($urandom_range(0, 99) < 2);
                sc   = ($urandom_range(0, 99) < 3);
                r    = int'($urandom_range(0, 99));
                mreq = (r < 4) ? ((m_mode == MODE_FIFO) ? MODE_LIFO : MODE_FIFO) : m_mode;
                step(iv, 8'($urandom), orr, mreq, fl, sc);
            end
        end
        step(1'b0, 8'h00, 1'b0, m_mode, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        run_small(5);
        run_small(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
